// File: rtl/bp_update_queue.sv
// bp_update_queue
// ---------------
// Small FIFO between branch resolution in EX and the 2-bit branch
// predictor's training port. Each accepted record holds {pc, taken, pred}.
// At most one record per cycle is drained into the predictor. The drain
// produces a registered one-cycle write strobe together with the outcome
// bit, the write PC and a mispredict flag.
//
// Optional feature: define BP_UPDATE_STATS_EN to build saturating counters
// for drained records (br_count) and drained mispredictions (mp_count).
// These counters clear only on rst. Without the macro both outputs are
// tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   res_valid     EX presents a resolved conditional branch
//   res_ready     queue has a free entry (depends on state only)
//   res_pc        branch PC
//   res_taken     actual outcome (1 = taken)
//   res_pred      outcome predicted at fetch
//   hold          predictor busy, no drain this cycle
//   flush         discard every queued record
//   we_bp         predictor write strobe, one cycle per record
//   update_res    outcome bit for the predictor counter
//   write_pc      PC of the record being written
//   mispredict    pulses with we_bp when taken != pred
//   q_count       current occupancy
//   br_count      drained records (optional feature)
//   mp_count      drained mispredictions (optional feature)

module bp_update_queue #(
  parameter int ADDR_WIDTH = 26,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [ADDR_WIDTH-1:0]      res_pc,
  input  logic                       res_taken,
  input  logic                       res_pred,
  input  logic                       hold,
  input  logic                       flush,
  output logic                       we_bp,
  output logic                       update_res,
  output logic [ADDR_WIDTH-1:0]      write_pc,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic [CNT_WIDTH-1:0]       br_count,
  output logic [CNT_WIDTH-1:0]       mp_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QCW   = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
    logic                  pred;
  } rec_t;

  rec_t                  mem_q [DEPTH];
  rec_t                  mem_d [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [QCW-1:0]        count_q, count_d;
  logic                  we_bp_q, we_bp_d;
  logic                  update_res_q, update_res_d;
  logic [ADDR_WIDTH-1:0] write_pc_q, write_pc_d;
  logic                  mispredict_q, mispredict_d;

  logic                  enq;
  logic                  drain;
  rec_t                  head;

  // res_ready is derived from occupancy alone. A full queue therefore
  // refuses input even in a cycle where it also drains.
  assign res_ready = (count_q != QCW'(DEPTH));
  assign enq       = res_valid && res_ready && !flush;
  assign drain     = (count_q != '0) && !hold && !flush;
  assign head      = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally when they
  // overflow their width.
  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    we_bp_d      = 1'b0;
    mispredict_d = 1'b0;
    update_res_d = update_res_q;
    write_pc_d   = write_pc_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = '{pc: res_pc, taken: res_taken, pred: res_pred};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (drain) begin
        we_bp_d      = 1'b1;
        update_res_d = head.taken;
        write_pc_d   = head.pc;
        mispredict_d = head.taken ^ head.pred;
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, drain})
        2'b10:   count_d = count_q + QCW'(1);
        2'b01:   count_d = count_q - QCW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      we_bp_q      <= 1'b0;
      update_res_q <= 1'b0;
      write_pc_q   <= '0;
      mispredict_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      we_bp_q      <= we_bp_d;
      update_res_q <= update_res_d;
      write_pc_q   <= write_pc_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign we_bp      = we_bp_q;
  assign update_res = update_res_q;
  assign write_pc   = write_pc_q;
  assign mispredict = mispredict_q;
  assign q_count    = count_q;

`ifdef BP_UPDATE_STATS_EN
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] mp_count_q, mp_count_d;

  // The counters advance on the same edge that launches the matching
  // we_bp/mispredict pulse, so they always agree with the visible pulses.
  // They saturate at all-ones, and flush leaves them untouched.
  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (drain && (br_count_q != '1)) begin
      br_count_d = br_count_q + CNT_WIDTH'(1);
    end
    if (drain && (head.taken ^ head.pred) && (mp_count_q != '1)) begin
      mp_count_d = mp_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;
`else
  assign br_count = '0;
  assign mp_count = '0;
`endif

endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- Sits between the execute stage's branch-resolution logic and the 2-bit branch predictor's training port.
- Buffers resolved conditional-branch records (PC, actual outcome, predicted outcome) in a small FIFO.
- Drains at most one record per cycle into the predictor as a single-cycle write strobe (we_bp), outcome bit (update_res) and write PC (write_pc).
- Decouples EX bursts from predictor write bandwidth; counts resolved branches and mispredictions.

Parameters:
- ADDR_WIDTH, 26, width of branch PC carried per record and driven on write_pc.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- CNT_WIDTH, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- res_valid  in  1  EX presents a resolved conditional branch this cycle
- res_ready  out  1  queue can accept a record this cycle
- res_pc  in  ADDR_WIDTH  PC of the resolved branch
- res_taken  in  1  actual outcome (1 = taken)
- res_pred  in  1  outcome predicted at fetch
- hold  in  1  predictor busy; suppresses drain this cycle
- flush  in  1  discard all queued records (used on pipeline reset)
- we_bp  out  1  predictor write strobe, one cycle per record
- update_res  out  1  outcome bit for the predictor counter update
- write_pc  out  ADDR_WIDTH  PC index source for the predictor update
- mispredict  out  1  pulses with we_bp when the drained record has res_pred != res_taken
- q_count  out  $clog2(DEPTH)+1  current occupancy
- br_count  out  CNT_WIDTH  total drained records (optional feature only)
- mp_count  out  CNT_WIDTH  total drained mispredictions (optional feature only)

Behaviour:
- Reset (rst=1 at posedge):
  - read pointer, write pointer and count cleared to 0.
  - we_bp, update_res, mispredict and write_pc all 0.
  - res_ready is 1 from the first cycle after reset.
  - stat counters cleared to 0.
  - Reset mid-operation drops all queued records; no write is issued on the reset cycle.
- Enqueue: occurs at posedge when res_valid && res_ready. Stores {res_pc, res_taken, res_pred} at the write pointer; the write pointer wraps modulo DEPTH.
- res_ready = (count != DEPTH). This is combinational from state only and must not depend on res_valid or on a same-cycle drain, so a full queue refuses input even if it drains that cycle.
- Drain: occurs at posedge when count != 0 && !hold && !flush.
  - Next cycle, registered outputs are we_bp=1, update_res=stored taken, write_pc=stored pc, mispredict=stored taken ^ stored pred.
  - The read pointer advances and wraps modulo DEPTH.
  - Otherwise we_bp=0 and mispredict=0 the next cycle; update_res and write_pc hold their last value.
- Latency: a record enqueued into an empty queue with hold=0 appears on we_bp exactly 2 cycles after its enqueue edge. There is no combinational pass-through.
- Simultaneous enqueue and drain: count is unchanged, both pointers advance.
- Ordering: strictly FIFO; records are never coalesced, even with the same PC.
- hold: freezes the read side only; enqueue continues until full.
- flush (sync, active-high): same effect as reset on pointers, count and we_bp. An enqueue on the flush cycle is discarded. Stat counters are NOT cleared by flush.
- Empty with hold=0: we_bp stays 0 and nothing is read.
- Overflow is impossible by construction. Behaviour with res_valid && !res_ready is a dropped request, and EX must retry.

Optional Feature:
- Macro: BP_UPDATE_STATS_EN.
- With the macro defined:
  - br_count increments on every we_bp pulse.
  - mp_count increments on every mispredict pulse.
  - Both saturate at all-ones and clear only on rst.
- Without the macro: br_count and mp_count are tied to 0 and no counter flops are synthesised. Queue behaviour is otherwise identical.

Test Plan:
- Enqueue pc=0x10, taken=1, pred=0 into empty queue, hold=0:
  - 2 cycles later we_bp=1, write_pc=0x10, update_res=1, mispredict=1 for exactly one cycle.
  - q_count returns to 0.
- hold=1, enqueue 4 records (DEPTH=4):
  - res_ready=0 after the 4th; a 5th res_valid is not accepted; q_count=4.
  - Release hold: 4 consecutive we_bp pulses in enqueue order, then res_ready=1.
- Continuous res_valid every cycle with hold=0:
  - q_count never exceeds 1.
  - we_bp high every cycle after the first 2; the pointers wrap past DEPTH without loss or reorder over 20 records.
- 3 records queued, flush=1 for one cycle with res_valid=1:
  - q_count=0 next cycle and no we_bp for the flushed or co-incident records.
  - With BP_UPDATE_STATS_EN defined, br_count is unchanged.
- rst asserted while 2 records queued and we_bp=1:
  - Next cycle we_bp=0, q_count=0, res_ready=1, and br_count/mp_count=0.
- BP_UPDATE_STATS_EN defined, drain 6 records with 2 mispredicts:
  - br_count=6, mp_count=2.
  - Without the macro, both read 0.
